// File: rtl/calc_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : calc_memory_arbiter
// Purpose  : Shares the calculator core's single-port synchronous memory
//            between the fetch stage and the data (load/store) stage.
//            Data has priority; a starvation counter lets fetch through
//            after MAX_STARVE consecutive contended denials. Read data is
//            routed back to the winner one cycle after its grant.
// Revision : 1.0 - initial release
// ============================================================================
module calc_memory_arbiter #(
   parameter int ADDRESS_WIDTH = 10,
   parameter int DATA_WIDTH    = 18,
   parameter int MAX_STARVE    = 3
) (
   input  logic                     CLK,
   input  logic                     Reset,
   input  logic                     Fetch_Req,
   input  logic [ADDRESS_WIDTH-1:0] Fetch_Address,
   output logic                     Fetch_Grant,
   output logic                     Fetch_Valid,
   output logic [DATA_WIDTH-1:0]    Fetch_Data,
   input  logic                     Data_Req,
   input  logic                     Data_Write,
   input  logic [ADDRESS_WIDTH-1:0] Data_Address,
   input  logic [DATA_WIDTH-1:0]    Data_Write_Data,
   output logic                     Data_Grant,
   output logic                     Data_Valid,
   output logic [DATA_WIDTH-1:0]    Data_Read_Data,
   output logic                     Mem_Enable,
   output logic                     Mem_Write,
   output logic [ADDRESS_WIDTH-1:0] Mem_Address,
   output logic [DATA_WIDTH-1:0]    Mem_Write_Data,
   input  logic [DATA_WIDTH-1:0]    Mem_Read_Data,
   output logic [3:0]               Starve_Count
);

   // The counter is 4 bits wide, so the threshold must fit in 1..15.
   generate
      if ((MAX_STARVE < 1) || (MAX_STARVE > 15)) begin : g_bad_max_starve
         $error("calc_memory_arbiter: MAX_STARVE must be in 1..15");
      end
   endgenerate

   localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

   logic fetch_win;
   logic data_win;
   logic sel_fetch_q;
   logic sel_data_q;

   // Arbitration: data first, unless fetch has been starved to the limit.
   always_comb begin
      fetch_win = 1'b0;
      data_win  = 1'b0;
      if (!Reset) begin
         if (Fetch_Req && Data_Req) begin
            if (Starve_Count == STARVE_LIMIT) begin
               fetch_win = 1'b1;
            end else begin
               data_win = 1'b1;
            end
         end else begin
            fetch_win = Fetch_Req;
            data_win  = Data_Req;
         end
      end
   end

   assign Fetch_Grant = fetch_win;
   assign Data_Grant  = data_win;

   // Memory command mux; everything is zero on idle cycles.
   always_comb begin
      Mem_Enable     = 1'b0;
      Mem_Write      = 1'b0;
      Mem_Address    = '0;
      Mem_Write_Data = '0;
      if (data_win) begin
         Mem_Enable     = 1'b1;
         Mem_Write      = Data_Write;
         Mem_Address    = Data_Address;
         Mem_Write_Data = Data_Write_Data;
      end else if (fetch_win) begin
         Mem_Enable     = 1'b1;
         Mem_Address    = Fetch_Address;
      end
   end

   // Starvation counter and read-return tags.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         Starve_Count <= 4'd0;
         sel_fetch_q  <= 1'b0;
         sel_data_q   <= 1'b0;
      end else begin
         sel_fetch_q <= fetch_win;
         sel_data_q  <= data_win & ~Data_Write;
         if (fetch_win || !Fetch_Req) begin
            Starve_Count <= 4'd0;
         end else if (data_win && (Starve_Count != STARVE_LIMIT)) begin
            Starve_Count <= Starve_Count + 4'd1;
         end
      end
   end

   // Gating the tags with Reset discards a read granted just before reset.
   assign Fetch_Valid    = sel_fetch_q & ~Reset;
   assign Data_Valid     = sel_data_q & ~Reset;
   assign Fetch_Data     = Fetch_Valid ? Mem_Read_Data : '0;
   assign Data_Read_Data = Data_Valid  ? Mem_Read_Data : '0;

endmodule
`default_nettype wire
